up_bus_arbiter_2to1: RTL and testbench
======================================

Name: up_bus_arbiter_2to1

Overview:
- Shares the single up_* register bus (wr/rd req-ack, one-cycle pulses) in front of the board register file between two masters.
- Typical masters: master 0 is the AXI4-Lite IPIF; master 1 is a debug or management bridge.
- Serializes all transactions, one outstanding on the slave side at a time, with round-robin fairness.
- Per-transaction timeout, so a non-responding slave cannot hang either master.

Parameters:
- C_ADDR_WIDTH, 10, register word-address width.
- C_DATA_WIDTH, 32, data width; byte enables are C_DATA_WIDTH/8.
- C_TIMEOUT, 255, max cycles to wait for slave ack after s_*_req (1..65535).
- C_TIMEOUT_DATA, 32'hDEADBEEF, read data returned on timeout.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- m_wr_addr  in  2*C_ADDR_WIDTH  write address, master k in slice k
- m_wr_req  in  2  write request pulse per master
- m_wr_be  in  2*C_DATA_WIDTH/8  write byte enables
- m_wr_din  in  2*C_DATA_WIDTH  write data
- m_wr_ack  out  2  write completion pulse per master
- m_rd_addr  in  2*C_ADDR_WIDTH  read address
- m_rd_req  in  2  read request pulse per master
- m_rd_dout  out  2*C_DATA_WIDTH  read data, valid with m_rd_ack
- m_rd_ack  out  2  read completion pulse per master
- s_wr_addr  out  C_ADDR_WIDTH  slave write address
- s_wr_req  out  1  slave write request pulse
- s_wr_be  out  C_DATA_WIDTH/8  slave byte enables
- s_wr_din  out  C_DATA_WIDTH  slave write data
- s_wr_ack  in  1  slave write ack pulse
- s_rd_addr  out  C_ADDR_WIDTH  slave read address
- s_rd_req  out  1  slave read request pulse
- s_rd_dout  in  C_DATA_WIDTH  slave read data, valid with s_rd_ack
- s_rd_ack  in  1  slave read ack pulse
- timeout_pulse  out  1  one-cycle pulse when a transaction times out

Behaviour:
- Reset (aresetn low, async): all outputs 0, all pending flags clear, state IDLE, rr pointer = master 0.
- Capture:
  - Each master has one write slot and one read slot.
  - m_*_req high with slot empty latches addr/be/din and sets pending.
  - req with slot already pending is dropped; the original is kept.
  - req in the same cycle its own slot completes is accepted (set wins).
- Arbitration in IDLE:
  - If only one master is pending, grant it; if both, grant the rr pointer master.
  - Within the granted master, write before read.
  - On completion, the rr pointer moves to the other master.
- FSM: IDLE -> ISSUE -> WAIT -> IDLE.
  - IDLE: on grant, register s_* addr/be/din and go to ISSUE.
  - ISSUE: s_wr_req or s_rd_req high exactly one cycle; load timeout counter = C_TIMEOUT; go to WAIT.
  - WAIT: count down each cycle.
  - WAIT, matching s_*_ack: the next cycle pulses the granted m_*_ack. For reads, the m_rd_dout slice is registered from s_rd_dout and held until that master's next read ack. Clear the slot; go to IDLE.
  - WAIT, counter reaches 0 without ack: next cycle pulses m_*_ack. Reads return C_TIMEOUT_DATA; writes are discarded. timeout_pulse asserts in the same cycle. Go to IDLE.
- Latency:
  - m req at cycle T: pending at T+1, s_req at T+2; a slave acking at T+3 gives m ack at T+4.
  - Back-to-back pending transactions: next s_req 2 cycles after the previous m ack.
- Ignored acks: s_*_ack outside WAIT, or of the wrong direction, is ignored (covers late ack after timeout).
- s_wr_* and s_rd_* address/data outputs hold their last value between transactions.
- Reset mid-transaction: the transaction is abandoned, no m ack is issued, and a later slave ack is ignored.

Test Plan:
- Single write: master 0 writes addr 0x004, data 0x12345678, be 0xF; slave acks 1 cycle after s_wr_req -> s_wr_req at T+2 with the same fields; m_wr_ack[0] at T+4; no pulse on m_wr_ack[1].
- Simultaneous reads: both masters read 0x000 and 0x008 in the same cycle; slave returns 0xA and 0xB -> master 0 served first with dout 0xA; master 1 next with 0xB; the following contention grants master 1 first.
- Write-then-read: master 1 issues write and read pulses in the same cycle -> write reaches the slave before the read; each gets exactly one ack.
- Timeout with C_TIMEOUT=4: slave never acks a read -> m_rd_ack and timeout_pulse 5 cycles after s_rd_req; dout 0xDEADBEEF; a late s_rd_ack 3 cycles later is ignored.
- Duplicate request: master 0 re-pulses wr_req with data 0x2 while 0x1 is pending -> the slave sees only 0x1; a single ack.
- Reset mid-WAIT: drop aresetn while waiting -> all outputs 0 immediately; no m ack is issued after release.

Source files
------------

// File: rtl/up_bus_arbiter_2to1.sv
// rtl/up_bus_arbiter_2to1.sv - two-master round-robin arbiter for the up_* register bus
module up_bus_arbiter_2to1 #(
    parameter int                      C_ADDR_WIDTH   = 10,
    parameter int                      C_DATA_WIDTH   = 32,
    parameter int                      C_TIMEOUT      = 255,
    parameter logic [C_DATA_WIDTH-1:0] C_TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [2*C_ADDR_WIDTH-1:0]     m_wr_addr,
    input  logic [1:0]                    m_wr_req,
    input  logic [2*(C_DATA_WIDTH/8)-1:0] m_wr_be,
    input  logic [2*C_DATA_WIDTH-1:0]     m_wr_din,
    output logic [1:0]                    m_wr_ack,
    input  logic [2*C_ADDR_WIDTH-1:0]     m_rd_addr,
    input  logic [1:0]                    m_rd_req,
    output logic [2*C_DATA_WIDTH-1:0]     m_rd_dout,
    output logic [1:0]                    m_rd_ack,
    output logic [C_ADDR_WIDTH-1:0]       s_wr_addr,
    output logic                          s_wr_req,
    output logic [C_DATA_WIDTH/8-1:0]     s_wr_be,
    output logic [C_DATA_WIDTH-1:0]       s_wr_din,
    input  logic                          s_wr_ack,
    output logic [C_ADDR_WIDTH-1:0]       s_rd_addr,
    output logic                          s_rd_req,
    input  logic [C_DATA_WIDTH-1:0]       s_rd_dout,
    input  logic                          s_rd_ack,
    output logic                          timeout_pulse
);

    localparam int         BW      = C_DATA_WIDTH / 8;
    localparam logic [15:0] TO_LOAD = 16'(C_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [1:0]              wr_pend, rd_pend;
    logic [C_ADDR_WIDTH-1:0] wr_addr_q [2];
    logic [C_ADDR_WIDTH-1:0] rd_addr_q [2];
    logic [BW-1:0]           wr_be_q   [2];
    logic [C_DATA_WIDTH-1:0] wr_din_q  [2];
    logic [C_DATA_WIDTH-1:0] rd_data_q [2];

    logic [C_ADDR_WIDTH-1:0] wr_addr_in [2];
    logic [C_ADDR_WIDTH-1:0] rd_addr_in [2];
    logic [BW-1:0]           wr_be_in   [2];
    logic [C_DATA_WIDTH-1:0] wr_din_in  [2];

    logic        gnt_m, gnt_m_nxt, gnt_wr, gnt_wr_nxt, rr;
    logic [15:0] cnt;
    logic        grant, cnt_ld, cnt_dec, fin, fin_to;
    logic        any0, any1, ack_busy, slv_ack;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wr_addr_in[k] = m_wr_addr[k*C_ADDR_WIDTH +: C_ADDR_WIDTH];
            rd_addr_in[k] = m_rd_addr[k*C_ADDR_WIDTH +: C_ADDR_WIDTH];
            wr_be_in[k]   = m_wr_be[k*BW +: BW];
            wr_din_in[k]  = m_wr_din[k*C_DATA_WIDTH +: C_DATA_WIDTH];
        end
    end

    assign m_rd_dout = {rd_data_q[1], rd_data_q[0]};

    // The ack cycle is also the slot-clear cycle, so arbitration sits it out.
    assign ack_busy = (|m_wr_ack) | (|m_rd_ack);
    assign slv_ack  = gnt_wr ? s_wr_ack : s_rd_ack;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= ST_IDLE;
            gnt_m  <= 1'b0;
            gnt_wr <= 1'b0;
        end else begin
            state  <= state_nxt;
            gnt_m  <= gnt_m_nxt;
            gnt_wr <= gnt_wr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_m_nxt  = gnt_m;
        gnt_wr_nxt = gnt_wr;
        grant      = 1'b0;
        cnt_ld     = 1'b0;
        cnt_dec    = 1'b0;
        fin        = 1'b0;
        fin_to     = 1'b0;
        any0       = wr_pend[0] | rd_pend[0];
        any1       = wr_pend[1] | rd_pend[1];
        case (state)
            ST_IDLE: begin
                if (!ack_busy && (any0 || any1)) begin
                    gnt_m_nxt  = (any0 && any1) ? rr : any1;
                    gnt_wr_nxt = wr_pend[gnt_m_nxt];
                    grant      = 1'b1;
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_ld    = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (slv_ack) begin
                    fin       = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt == 16'd1) begin
                    fin       = 1'b1;
                    fin_to    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_pend       <= '0;
            rd_pend       <= '0;
            for (int k = 0; k < 2; k++) begin
                wr_addr_q[k] <= '0;
                rd_addr_q[k] <= '0;
                wr_be_q[k]   <= '0;
                wr_din_q[k]  <= '0;
                rd_data_q[k] <= '0;
            end
            rr            <= 1'b0;
            cnt           <= '0;
            s_wr_addr     <= '0;
            s_wr_req      <= 1'b0;
            s_wr_be       <= '0;
            s_wr_din      <= '0;
            s_rd_addr     <= '0;
            s_rd_req      <= 1'b0;
            m_wr_ack      <= '0;
            m_rd_ack      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            // A request landing in its slot's ack cycle refills the slot.
            for (int k = 0; k < 2; k++) begin
                if (m_wr_req[k] && (!wr_pend[k] || m_wr_ack[k])) begin
                    wr_pend[k]   <= 1'b1;
                    wr_addr_q[k] <= wr_addr_in[k];
                    wr_be_q[k]   <= wr_be_in[k];
                    wr_din_q[k]  <= wr_din_in[k];
                end else if (m_wr_ack[k]) begin
                    wr_pend[k] <= 1'b0;
                end
                if (m_rd_req[k] && (!rd_pend[k] || m_rd_ack[k])) begin
                    rd_pend[k]   <= 1'b1;
                    rd_addr_q[k] <= rd_addr_in[k];
                end else if (m_rd_ack[k]) begin
                    rd_pend[k] <= 1'b0;
                end
            end

            if (ack_busy)
                rr <= ~gnt_m;

            s_wr_req <= 1'b0;
            s_rd_req <= 1'b0;
            if (grant) begin
                if (gnt_wr_nxt) begin
                    s_wr_addr <= wr_addr_q[gnt_m_nxt];
                    s_wr_be   <= wr_be_q[gnt_m_nxt];
                    s_wr_din  <= wr_din_q[gnt_m_nxt];
                    s_wr_req  <= 1'b1;
                end else begin
                    s_rd_addr <= rd_addr_q[gnt_m_nxt];
                    s_rd_req  <= 1'b1;
                end
            end

            if (cnt_ld)
                cnt <= TO_LOAD;
            else if (cnt_dec)
                cnt <= cnt - 16'd1;

            m_wr_ack      <= '0;
            m_rd_ack      <= '0;
            timeout_pulse <= 1'b0;
            if (fin) begin
                timeout_pulse <= fin_to;
                if (gnt_wr) begin
                    m_wr_ack[gnt_m] <= 1'b1;
                end else begin
                    m_rd_ack[gnt_m]  <= 1'b1;
                    rd_data_q[gnt_m] <= fin_to ? C_TIMEOUT_DATA : s_rd_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_up_bus_arbiter_2to1.sv
// tb/tb_up_bus_arbiter_2to1.sv - directed vector bench for up_bus_arbiter_2to1
module tb_up_bus_arbiter_2to1;

    localparam int AW = 10;
    localparam int DW = 32;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [2*AW-1:0] m_wr_addr;
    logic [1:0]      m_wr_req;
    logic [7:0]      m_wr_be;
    logic [2*DW-1:0] m_wr_din;
    logic [1:0]      m_wr_ack;
    logic [2*AW-1:0] m_rd_addr;
    logic [1:0]      m_rd_req;
    logic [2*DW-1:0] m_rd_dout;
    logic [1:0]      m_rd_ack;
    logic [AW-1:0]   s_wr_addr;
    logic            s_wr_req;
    logic [3:0]      s_wr_be;
    logic [DW-1:0]   s_wr_din;
    logic            s_wr_ack;
    logic [AW-1:0]   s_rd_addr;
    logic            s_rd_req;
    logic [DW-1:0]   s_rd_dout;
    logic            s_rd_ack;
    logic            timeout_pulse;

    up_bus_arbiter_2to1 #(
        .C_ADDR_WIDTH  (AW),
        .C_DATA_WIDTH  (DW),
        .C_TIMEOUT     (4),
        .C_TIMEOUT_DATA(32'hDEADBEEF)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .m_wr_addr    (m_wr_addr),
        .m_wr_req     (m_wr_req),
        .m_wr_be      (m_wr_be),
        .m_wr_din     (m_wr_din),
        .m_wr_ack     (m_wr_ack),
        .m_rd_addr    (m_rd_addr),
        .m_rd_req     (m_rd_req),
        .m_rd_dout    (m_rd_dout),
        .m_rd_ack     (m_rd_ack),
        .s_wr_addr    (s_wr_addr),
        .s_wr_req     (s_wr_req),
        .s_wr_be      (s_wr_be),
        .s_wr_din     (s_wr_din),
        .s_wr_ack     (s_wr_ack),
        .s_rd_addr    (s_rd_addr),
        .s_rd_req     (s_rd_req),
        .s_rd_dout    (s_rd_dout),
        .s_rd_ack     (s_rd_ack),
        .timeout_pulse(timeout_pulse)
    );

    always #5 aclk = ~aclk;

    // Expected strobe vector: {s_wr_req, s_rd_req, m_wr_ack[1:0], m_rd_ack[1:0], timeout_pulse}
    localparam logic [6:0] Z   = 7'b0000000;
    localparam logic [6:0] SWR = 7'b1000000;
    localparam logic [6:0] SRD = 7'b0100000;
    localparam logic [6:0] WA1 = 7'b0010000;
    localparam logic [6:0] WA0 = 7'b0001000;
    localparam logic [6:0] RA1 = 7'b0000100;
    localparam logic [6:0] RA0 = 7'b0000010;

    typedef struct {
        logic [1:0]  wr;
        logic [1:0]  rd;
        logic [31:0] din;
        logic        swa;
        logic        sra;
        logic [31:0] sdout;
        logic [6:0]  exp;
        logic [9:0]  ea;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(input logic [1:0] wr, input logic [1:0] rd, input logic [31:0] din,
                                input logic swa, input logic sra, input logic [31:0] sdout,
                                input logic [6:0] exp, input logic [9:0] ea, input logic [31:0] ed);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.swa = swa; v.sra = sra;
        v.sdout = sdout; v.exp = exp; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [6:0] strobes();
        return {s_wr_req, s_rd_req, m_wr_ack, m_rd_ack, timeout_pulse};
    endfunction

    function automatic logic any_out();
        return |{m_wr_ack, m_rd_dout, m_rd_ack, s_wr_addr, s_wr_req, s_wr_be,
                 s_wr_din, s_rd_addr, s_rd_req, timeout_pulse};
    endfunction

    initial begin
        logic found;
        aresetn   = 1'b0;
        m_wr_addr = {10'h010, 10'h004};
        m_rd_addr = {10'h008, 10'h000};
        m_wr_be   = {4'h3, 4'hF};
        m_wr_din  = '0;
        m_wr_req  = '0;
        m_rd_req  = '0;
        s_wr_ack  = 1'b0;
        s_rd_ack  = 1'b0;
        s_rd_dout = '0;

        // simultaneous reads, rr starts at master 0
        vecs.push_back(mk(2'b00, 2'b11, 0, 0, 0, 0, Z,   0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, SRD, 10'h000, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 1, 32'hA, RA0, 0, 32'hA));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, SRD, 10'h008, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 1, 32'hB, RA1, 0, 32'hB));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        // single write from master 0
        vecs.push_back(mk(2'b01, 2'b00, 32'h12345678, 0, 0, 0, Z, 0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, SWR, 10'h004, 32'h12345678));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 1, 0, 0, WA0, 0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        // contention after master 0 was served: master 1 first
        vecs.push_back(mk(2'b11, 2'b00, 32'hC3, 0, 0, 0, Z, 0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, SWR, 10'h010, 32'hC3));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 1, 0, 0, WA1, 0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, SWR, 10'h004, 32'hC3));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 1, 0, 0, WA0, 0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        // master 1 write and read together: write goes first
        vecs.push_back(mk(2'b10, 2'b10, 32'h55, 0, 0, 0, Z, 0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, SWR, 10'h010, 32'h55));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 1, 0, 0, WA1, 0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, SRD, 10'h008, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 1, 32'h77, RA1, 0, 32'h77));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        // duplicate requests while pending are dropped
        vecs.push_back(mk(2'b01, 2'b00, 32'h1, 0, 0, 0, Z, 0, 0));
        vecs.push_back(mk(2'b01, 2'b00, 32'h2, 0, 0, 0, SWR, 10'h004, 32'h1));
        vecs.push_back(mk(2'b01, 2'b00, 32'h3, 0, 0, 0, Z, 0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 1, 0, 0, WA0, 0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, Z,   0, 0));

        step();
        step();
        chk("reset_outputs", any_out(), 0);
        aresetn = 1'b1;

        foreach (vecs[i]) begin
            m_wr_req  = vecs[i].wr;
            m_rd_req  = vecs[i].rd;
            m_wr_din  = {vecs[i].din, vecs[i].din};
            s_wr_ack  = vecs[i].swa;
            s_rd_ack  = vecs[i].sra;
            s_rd_dout = vecs[i].sdout;
            step();
            chk($sformatf("vec%0d_strobes", i), strobes(), vecs[i].exp);
            if (vecs[i].exp[6]) begin
                chk($sformatf("vec%0d_s_wr_addr", i), s_wr_addr, vecs[i].ea);
                chk($sformatf("vec%0d_s_wr_din", i), s_wr_din, vecs[i].ed);
                chk($sformatf("vec%0d_s_wr_be", i), s_wr_be, (vecs[i].ea == 10'h004) ? 4'hF : 4'h3);
            end
            if (vecs[i].exp[5])
                chk($sformatf("vec%0d_s_rd_addr", i), s_rd_addr, vecs[i].ea);
            if (vecs[i].exp[1])
                chk($sformatf("vec%0d_dout0", i), m_rd_dout[31:0], vecs[i].ed);
            if (vecs[i].exp[2])
                chk($sformatf("vec%0d_dout1", i), m_rd_dout[63:32], vecs[i].ed);
        end
        m_wr_req = '0; m_rd_req = '0; s_wr_ack = 1'b0; s_rd_ack = 1'b0;

        // read timeout with a silent slave, then a late ack
        m_rd_req = 2'b01;
        step();
        m_rd_req = 2'b00;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (s_rd_req) found = 1'b1;
        end
        chk("to_s_rd_req_seen", found, 1);
        chk("to_s_rd_addr", s_rd_addr, 10'h000);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("to_cycle%0d", i), {m_rd_ack, timeout_pulse}, (i == 5) ? 3'b011 : 3'b000);
        end
        chk("to_dout0", m_rd_dout[31:0], 32'hDEADBEEF);
        step();
        step();
        s_rd_ack  = 1'b1;
        s_rd_dout = 32'h1111;
        step();
        s_rd_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("late_ack_ignored%0d", i), strobes(), Z);
        end
        chk("late_ack_dout0", m_rd_dout[31:0], 32'hDEADBEEF);

        // reset while waiting on the slave
        m_wr_din = {32'h99, 32'h99};
        m_wr_req = 2'b10;
        step();
        m_wr_req = 2'b00;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (s_wr_req) found = 1'b1;
        end
        chk("rst_s_wr_req_seen", found, 1);
        step();
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst_async_outputs", any_out(), 0);
        step();
        aresetn  = 1'b1;
        s_wr_ack = 1'b1;
        step();
        s_wr_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rst_no_ack%0d", i), strobes(), Z);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
